ysyx_23060201_mem_arbiter: RTL and testbench
============================================

YSYX_23060201_MEM_ARBITER -- requirements
Module: ysyx_23060201_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 32, meaning the address width on every port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data width on every port.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ifu_req_valid  in  1  instruction-fetch read request.
REQ-006 SHALL have port ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-007 SHALL have port ifu_addr  in  MEM_ADDR_WIDTH  IFU read address.
REQ-008 SHALL have port ifu_resp_valid  out  1  IFU response available on rsp_rdata.
REQ-009 SHALL have port ifu_resp_ready  in  1  IFU consumes the response.
REQ-010 SHALL have port lsu_req_valid  in  1  load/store request.
REQ-011 SHALL have port lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-012 SHALL have port lsu_wen  in  1  1 means write, 0 means read.
REQ-013 SHALL have port lsu_addr  in  MEM_ADDR_WIDTH  LSU address.
REQ-014 SHALL have port lsu_wdata  in  DATA_WIDTH  LSU write data.
REQ-015 SHALL have port lsu_mask  in  8  LSU byte mask, used for reads and writes.
REQ-016 SHALL have port lsu_resp_valid  out  1  LSU response or write acknowledge available.
REQ-017 SHALL have port lsu_resp_ready  in  1  LSU consumes the response.
REQ-018 SHALL have port rsp_rdata  out  DATA_WIDTH  response data for the current owner.
REQ-019 SHALL have port mem_ren  out  1  memory read strobe.
REQ-020 SHALL have port mem_raddr  out  MEM_ADDR_WIDTH  memory read address.
REQ-021 SHALL have port mem_rmask  out  8  memory read mask.
REQ-022 SHALL have port mem_wen  out  1  memory write strobe.
REQ-023 SHALL have port mem_waddr  out  MEM_ADDR_WIDTH  memory write address.
REQ-024 SHALL have port mem_wdata  out  DATA_WIDTH  memory write data.
REQ-025 SHALL have port mem_wmask  out  8  memory write mask.
REQ-026 SHALL have port mem_rdata  in  DATA_WIDTH  memory read data, registered by the memory and valid in the cycle after mem_ren.

Function
REQ-027 SHALL implement an FSM IDLE->ACCESS->LATCH->RESP->IDLE with exactly one transaction outstanding.
REQ-028 In IDLE, SHALL assert req_ready combinationally only to the arbitration winner whose req_valid=1, and SHALL move to ACCESS on that handshake; with no request present, SHALL stay in IDLE.
REQ-029 On acceptance, SHALL latch owner, address, wen, wdata and mask; IFU requests use read with mask 8'h0F.
REQ-030 In ACCESS (exactly 1 cycle), SHALL drive mem_ren=1 for reads or mem_wen=1 for writes from the latched values; both strobes are 0 in every other state, and the two strobes are never 1 together.
REQ-031 In LATCH, SHALL load rsp_rdata from mem_rdata for reads and load 0 for writes.
REQ-032 In RESP, SHALL hold the owner's resp_valid=1 and rsp_rdata stable until resp_ready=1, then return to IDLE; the non-owner's resp_valid stays 0.
REQ-033 Latency: handshake in cycle N, strobe in N+1, resp_valid from N+3; minimum back-to-back accept interval 4 cycles.
REQ-034 Requests arriving while not in IDLE SHALL see req_ready=0 and wait; requesters must hold their request stable until accepted.

Reset
REQ-035 While rst=1 at a clock edge, SHALL go to IDLE, set rsp_rdata=0, set all resp_valid, req_ready and mem strobes to 0, and set last_grant=IFU.
REQ-036 Reset mid-transaction SHALL drop it with no response; a strobe already issued is not retracted.

Configuration
REQ-037 With macro YSYX_23060201_ARB_RR_EN defined, ties SHALL go to the requester not granted last (round-robin via last_grant).
REQ-038 Without the macro, LSU SHALL always win ties (fixed priority), and last_grant is not implemented.

Verification
REQ-039 IFU read only, addr 0x80000000, memory word 0x00000413: bench SHALL see mem_ren pulse 1 cycle after accept, ifu_resp_valid 3 cycles after accept, rsp_rdata=0x00000413.
REQ-040 LSU write addr 0x80001000, data 0xDEADBEEF, mask 0x0F: bench SHALL see a single mem_wen pulse with those values, then lsu_resp_valid with rsp_rdata=0.
REQ-041 Both requesting every cycle for 4 transactions: with the macro, grants SHALL be LSU, IFU, LSU, IFU; without it, grants SHALL be LSU×4.
REQ-042 Response back-pressure, resp_ready held 0 for 5 cycles: resp_valid and rsp_rdata SHALL stay constant, with no new accept and no strobes.
REQ-043 rst asserted during LATCH: bench SHALL see no resp_valid, the next cycle in IDLE, and a fresh request served normally.

Source files
------------

// File: rtl/ysyx_23060201_mem_arbiter.sv
// IFU/LSU memory arbiter: one transaction in flight, IDLE->ACCESS->LATCH->RESP.
// Define YSYX_23060201_ARB_RR_EN for round-robin tie breaking; otherwise LSU wins ties.
module ysyx_23060201_mem_arbiter #(
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ifu_req_valid,
   output logic                      ifu_req_ready,
   input  logic [MEM_ADDR_WIDTH-1:0] ifu_addr,
   output logic                      ifu_resp_valid,
   input  logic                      ifu_resp_ready,
   input  logic                      lsu_req_valid,
   output logic                      lsu_req_ready,
   input  logic                      lsu_wen,
   input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata,
   input  logic [7:0]                lsu_mask,
   output logic                      lsu_resp_valid,
   input  logic                      lsu_resp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      mem_ren,
   output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
   output logic [7:0]                mem_rmask,
   output logic                      mem_wen,
   output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [7:0]                mem_wmask,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LATCH, S_RESP} state_t;
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      r_owner;
   logic                      r_wen;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [7:0]                r_mask;
   logic [DATA_WIDTH-1:0]     r_rdata;
   logic                      w_grant_lsu;
   logic                      w_accept;
   logic                      w_resp_done;

`ifdef YSYX_23060201_ARB_RR_EN
   logic r_last_grant;

   // On a tie the LSU loses only if it was the previous winner.
   assign w_grant_lsu = lsu_req_valid && !(ifu_req_valid && (r_last_grant == OWN_LSU));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= OWN_IFU;
      end else if (w_accept) begin
         r_last_grant <= w_grant_lsu;
      end
   end
`else
   assign w_grant_lsu = lsu_req_valid;
`endif

   assign ifu_req_ready = !rst && (r_state == S_IDLE) && ifu_req_valid && !w_grant_lsu;
   assign lsu_req_ready = !rst && (r_state == S_IDLE) && w_grant_lsu;
   assign w_accept      = ifu_req_ready || lsu_req_ready;
   assign w_resp_done   = (r_owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

   always_comb begin
      w_state_nxt    = r_state;
      mem_ren        = 1'b0;
      mem_wen        = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      unique case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_ACCESS;
         S_ACCESS: begin
            mem_ren     = !r_wen;
            mem_wen     = r_wen;
            w_state_nxt = S_LATCH;
         end
         S_LATCH:  w_state_nxt = S_RESP;
         S_RESP: begin
            ifu_resp_valid = (r_owner == OWN_IFU);
            lsu_resp_valid = (r_owner == OWN_LSU);
            if (w_resp_done) w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_LATCH) r_rdata <= r_wen ? '0 : mem_rdata;
      end
   end

   // NOTE: request capture registers need no reset; they are only observed after an accept loads them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_owner <= w_grant_lsu;
         if (w_grant_lsu) begin
            r_wen   <= lsu_wen;
            r_addr  <= lsu_addr;
            r_wdata <= lsu_wdata;
            r_mask  <= lsu_mask;
         end else begin
            r_wen   <= 1'b0;
            r_addr  <= ifu_addr;
            r_wdata <= '0;
            r_mask  <= 8'h0F;
         end
      end
   end

   assign rsp_rdata = r_rdata;
   assign mem_raddr = r_addr;
   assign mem_rmask = r_mask;
   assign mem_waddr = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wmask = r_mask;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for ysyx_23060201_mem_arbiter with a one-cycle registered memory model.
// Define YSYX_23060201_ARB_RR_EN here as well when building the round-robin variant.
module tb_ysyx_23060201_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
   logic [31:0] ifu_addr = '0;
   logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0;
   logic [31:0] lsu_addr = '0, lsu_wdata = '0;
   logic [7:0]  lsu_mask = '0;
   logic [31:0] rsp_rdata;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata;
   logic [7:0]  mem_rmask, mem_wmask;
   logic [31:0] mem_rdata = '0;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int ren_cnt = 0;
   int wen_cnt = 0;

   ysyx_23060201_mem_arbiter #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
      .rsp_rdata(rsp_rdata),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_5A5A);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_ren) begin
         mem_rdata <= mem_word(mem_raddr);
         ren_cnt   <= ren_cnt + 1;
      end
      if (mem_wen) wen_cnt <= wen_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      tick(); tick(); #1;
      tests++; if (ifu_req_ready !== 1'b0) begin failed++; $display("FAIL reset_ifu_ready: got %0h want 0", ifu_req_ready); end
      tests++; if (lsu_req_ready !== 1'b0) begin failed++; $display("FAIL reset_lsu_ready: got %0h want 0", lsu_req_ready); end
      tests++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin failed++; $display("FAIL reset_resp_valid: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      tests++; if ({mem_ren, mem_wen} !== 2'b00) begin failed++; $display("FAIL reset_strobes: got %b want 00", {mem_ren, mem_wen}); end
      tests++; if (rsp_rdata !== 32'h0) begin failed++; $display("FAIL reset_rdata: got %h want 00000000", rsp_rdata); end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; rst = 1'b0;
      tick(); tick(); #1;
      tests++; if ({ifu_req_ready, lsu_req_ready, mem_ren, mem_wen} !== 4'b0000) begin failed++; $display("FAIL idle_no_req: got %b want 0000", {ifu_req_ready, lsu_req_ready, mem_ren, mem_wen}); end
   endtask

   task automatic test_ifu_read();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1'b0;
      #1;
      tests++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin failed++; $display("FAIL ifu_accept: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
      tick(); ifu_req_valid = 1'b0; #1;
      tests++; if ({mem_ren, mem_wen} !== 2'b10) begin failed++; $display("FAIL ifu_strobe: got %b want 10", {mem_ren, mem_wen}); end
      tests++; if (mem_raddr !== 32'h8000_0000) begin failed++; $display("FAIL ifu_raddr: got %h want 80000000", mem_raddr); end
      tests++; if (mem_rmask !== 8'h0F) begin failed++; $display("FAIL ifu_rmask: got %h want 0f", mem_rmask); end
      tick(); #1;
      tests++; if ({mem_ren, ifu_resp_valid} !== 2'b00) begin failed++; $display("FAIL ifu_latch_cycle: got %b want 00", {mem_ren, ifu_resp_valid}); end
      tick(); #1;
      tests++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b10) begin failed++; $display("FAIL ifu_resp_valid: got %b want 10", {ifu_resp_valid, lsu_resp_valid}); end
      tests++; if (rsp_rdata !== 32'h0000_0413) begin failed++; $display("FAIL ifu_rdata: got %h want 00000413", rsp_rdata); end
      ifu_resp_ready = 1'b1;
      tick(); ifu_resp_ready = 1'b0; #1;
      tests++; if (ifu_resp_valid !== 1'b0) begin failed++; $display("FAIL ifu_resp_drop: got %0h want 0", ifu_resp_valid); end
   endtask

   task automatic test_lsu_write();
      int w0;
      w0 = wen_cnt;
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF; lsu_mask = 8'h0F; lsu_resp_ready = 1'b0;
      #1;
      tests++; if (lsu_req_ready !== 1'b1) begin failed++; $display("FAIL lsu_accept: got %0h want 1", lsu_req_ready); end
      tick(); lsu_req_valid = 1'b0; #1;
      tests++; if ({mem_wen, mem_ren} !== 2'b10) begin failed++; $display("FAIL lsu_strobe: got %b want 10", {mem_wen, mem_ren}); end
      tests++; if ({mem_waddr, mem_wdata, mem_wmask} !== {32'h8000_1000, 32'hDEAD_BEEF, 8'h0F}) begin failed++; $display("FAIL lsu_wvals: got %h %h %h want 80001000 deadbeef 0f", mem_waddr, mem_wdata, mem_wmask); end
      tick(); #1;
      tests++; if (mem_wen !== 1'b0) begin failed++; $display("FAIL lsu_wen_pulse: got %0h want 0", mem_wen); end
      tick(); #1;
      tests++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin failed++; $display("FAIL lsu_resp_valid: got %b want 10", {lsu_resp_valid, ifu_resp_valid}); end
      tests++; if (rsp_rdata !== 32'h0) begin failed++; $display("FAIL lsu_wr_rdata: got %h want 00000000", rsp_rdata); end
      tests++; if (wen_cnt - w0 !== 1) begin failed++; $display("FAIL lsu_wen_count: got %0d want 1", wen_cnt - w0); end
      lsu_resp_ready = 1'b1;
      tick(); lsu_resp_ready = 1'b0; lsu_wen = 1'b0; #1;
      tests++; if (lsu_resp_valid !== 1'b0) begin failed++; $display("FAIL lsu_resp_drop: got %0h want 0", lsu_resp_valid); end
   endtask

   task automatic test_arbitration();
      int  last_cyc;
      int  waited;
      logic exp_lsu;
      rst = 1'b1; tick(); rst = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000; lsu_mask = 8'h0F;
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      last_cyc = 0;
      for (int t = 0; t < 4; t++) begin
         waited = 0;
         #1;
         while (!(ifu_req_ready || lsu_req_ready) && waited < 8) begin
            tick(); #1; waited++;
         end
         tests++; if (waited >= 8) begin failed++; $display("FAIL arb_timeout_%0d: got no accept want accept", t); end
`ifdef YSYX_23060201_ARB_RR_EN
         exp_lsu = (t % 2 == 0);
`else
         exp_lsu = 1'b1;
`endif
         tests++; if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin failed++; $display("FAIL arb_grant_%0d: got lsu/ifu %b want %b", t, {lsu_req_ready, ifu_req_ready}, {exp_lsu, !exp_lsu}); end
         if (t > 0) begin
            tests++; if (cyc - last_cyc !== 4) begin failed++; $display("FAIL arb_interval_%0d: got %0d want 4", t, cyc - last_cyc); end
         end
         last_cyc = cyc;
         tick();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      tick(); tick(); tick(); #1;
      tests++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin failed++; $display("FAIL arb_drain: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int r0, w0;
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000; lsu_mask = 8'hFF;
      lsu_resp_ready = 1'b0; ifu_resp_ready = 1'b0;
      #1;
      tests++; if (lsu_req_ready !== 1'b1) begin failed++; $display("FAIL bp_accept: got %0h want 1", lsu_req_ready); end
      tick(); lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
      tick(); tick(); #1;
      r0 = ren_cnt; w0 = wen_cnt;
      for (int i = 0; i < 5; i++) begin
         tests++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin failed++; $display("FAIL bp_valid_%0d: got %b want 10", i, {lsu_resp_valid, ifu_resp_valid}); end
         tests++; if (rsp_rdata !== 32'h25A5_6A5A) begin failed++; $display("FAIL bp_rdata_%0d: got %h want 25a56a5a", i, rsp_rdata); end
         tests++; if ({ifu_req_ready, mem_ren, mem_wen} !== 3'b000) begin failed++; $display("FAIL bp_quiet_%0d: got %b want 000", i, {ifu_req_ready, mem_ren, mem_wen}); end
         tick(); #1;
      end
      tests++; if ({ren_cnt - r0, wen_cnt - w0} !== {32'd0, 32'd0}) begin failed++; $display("FAIL bp_strobe_count: got %0d/%0d want 0/0", ren_cnt - r0, wen_cnt - w0); end
      ifu_req_valid = 1'b0; lsu_resp_ready = 1'b1;
      tick(); lsu_resp_ready = 1'b0; #1;
      tests++; if (lsu_resp_valid !== 1'b0) begin failed++; $display("FAIL bp_release: got %0h want 0", lsu_resp_valid); end
   endtask

   task automatic test_reset_mid();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1'b1;
      #1;
      tests++; if (ifu_req_ready !== 1'b1) begin failed++; $display("FAIL rm_accept: got %0h want 1", ifu_req_ready); end
      tick(); ifu_req_valid = 1'b0;
      tick(); rst = 1'b1; #1;
      tests++; if (ifu_resp_valid !== 1'b0) begin failed++; $display("FAIL rm_latch_valid: got %0h want 0", ifu_resp_valid); end
      tick(); rst = 1'b0; ifu_req_valid = 1'b1; #1;
      tests++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin failed++; $display("FAIL rm_no_resp: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      tests++; if (rsp_rdata !== 32'h0) begin failed++; $display("FAIL rm_rdata_clear: got %h want 00000000", rsp_rdata); end
      tests++; if (ifu_req_ready !== 1'b1) begin failed++; $display("FAIL rm_idle_ready: got %0h want 1", ifu_req_ready); end
      tick(); ifu_req_valid = 1'b0; #1;
      tests++; if (mem_ren !== 1'b1) begin failed++; $display("FAIL rm_fresh_ren: got %0h want 1", mem_ren); end
      tick(); tick(); #1;
      tests++; if ({ifu_resp_valid, rsp_rdata} !== {1'b1, 32'h0000_0413}) begin failed++; $display("FAIL rm_fresh_resp: got %0h %h want 1 00000413", ifu_resp_valid, rsp_rdata); end
      tick(); ifu_resp_ready = 1'b0; #1;
      tests++; if (ifu_resp_valid !== 1'b0) begin failed++; $display("FAIL rm_fresh_done: got %0h want 0", ifu_resp_valid); end
   endtask

   initial begin
      test_reset();
      test_ifu_read();
      test_lsu_write();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
